// File: rtl/push_conditioner.sv
// Push-button front end: per-button synchroniser, debounce, press/auto-repeat
// pulse generation and event stretching for slow-clock consumers.
module push_conditioner #(
    parameter int unsigned          NUM_BTN         = 5,
    parameter int unsigned          DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned          REPEAT_DELAY    = 50_000_000,
    parameter int unsigned          REPEAT_PERIOD   = 20_000_000,
    parameter logic [NUM_BTN-1:0]   REPEAT_MASK     = NUM_BTN'(5'b00011),
    parameter int unsigned          STRETCH_CYCLES  = 100_000_000
) (
    input  logic               clk_osc,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] push_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_event
);

    localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned REP_W_D = $clog2(REPEAT_DELAY + 1);
    localparam int unsigned REP_W_P = $clog2(REPEAT_PERIOD + 1);
    localparam int unsigned REP_W   = (REP_W_D > REP_W_P) ? REP_W_D : REP_W_P;
    localparam int unsigned ST_W    = $clog2(STRETCH_CYCLES + 1);

    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);
    localparam logic [ST_W-1:0]  ST_LOAD     = ST_W'(STRETCH_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HELD   = 2'd1,
        ST_REPEAT = 2'd2
    } rep_state_t;

    for (genvar gi = 0; gi < int'(NUM_BTN); gi++) begin : g_btn
        logic             r_s1;
        logic             r_s2;
        logic             r_level;
        logic [DB_W-1:0]  r_db_cnt;
        rep_state_t       r_state;
        logic [REP_W-1:0] r_rep_cnt;
        logic             r_press;
        logic [ST_W-1:0]  r_st_cnt;
        logic             r_event;
        logic             w_rep_en;
        logic             w_fire;

        assign w_rep_en = REPEAT_MASK[gi];

        // Two-flop synchroniser followed by the stable-level debounce counter.
        always_ff @(posedge clk_osc or posedge reset) begin
            if (reset) begin
                r_s1     <= 1'b0;
                r_s2     <= 1'b0;
                r_level  <= 1'b0;
                r_db_cnt <= '0;
            end else begin
                r_s1 <= push_raw[gi];
                r_s2 <= r_s1;
                if (r_s2 == r_level) begin
                    r_db_cnt <= '0;
                end else if (r_db_cnt == DB_LAST) begin
                    r_level  <= r_s2;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + DB_W'(1);
                end
            end
        end

        // Press/repeat decode; shared by the pulse register and the stretcher.
        always_comb begin
            w_fire = 1'b0;
            case (r_state)
                ST_IDLE:   w_fire = r_level;
                ST_HELD:   w_fire = r_level && w_rep_en && (r_rep_cnt == DELAY_LAST);
                ST_REPEAT: w_fire = r_level && (r_rep_cnt == PERIOD_LAST);
                default:   w_fire = 1'b0;
            endcase
        end

        // Repeat FSM; non-repeating buttons park in HELD with the counter idle.
        always_ff @(posedge clk_osc or posedge reset) begin
            if (reset) begin
                r_state   <= ST_IDLE;
                r_rep_cnt <= '0;
                r_press   <= 1'b0;
            end else begin
                r_press <= w_fire;
                case (r_state)
                    ST_IDLE: begin
                        r_rep_cnt <= '0;
                        if (r_level) begin
                            r_state <= ST_HELD;
                        end
                    end
                    ST_HELD: begin
                        if (!r_level) begin
                            r_state   <= ST_IDLE;
                            r_rep_cnt <= '0;
                        end else if (w_rep_en) begin
                            if (r_rep_cnt == DELAY_LAST) begin
                                r_state   <= ST_REPEAT;
                                r_rep_cnt <= '0;
                            end else begin
                                r_rep_cnt <= r_rep_cnt + REP_W'(1);
                            end
                        end
                    end
                    ST_REPEAT: begin
                        if (!r_level) begin
                            r_state   <= ST_IDLE;
                            r_rep_cnt <= '0;
                        end else if (r_rep_cnt == PERIOD_LAST) begin
                            r_rep_cnt <= '0;
                        end else begin
                            r_rep_cnt <= r_rep_cnt + REP_W'(1);
                        end
                    end
                    default: begin
                        r_state   <= ST_IDLE;
                        r_rep_cnt <= '0;
                    end
                endcase
            end
        end

        // Event stretcher: every pulse reloads, so close pulses merge.
        always_ff @(posedge clk_osc or posedge reset) begin
            if (reset) begin
                r_st_cnt <= '0;
                r_event  <= 1'b0;
            end else if (w_fire) begin
                r_st_cnt <= ST_LOAD;
                r_event  <= 1'b1;
            end else if (r_st_cnt != '0) begin
                r_st_cnt <= r_st_cnt - ST_W'(1);
                r_event  <= (r_st_cnt != ST_W'(1));
            end
        end

        assign btn_level[gi] = r_level;
        assign btn_press[gi] = r_press;
        assign btn_event[gi] = r_event;
    end

endmodule

// File: tb/tb_push_conditioner.sv
// Directed bench for push_conditioner: per-edge capture windows compared
// against hand-computed bit masks (bit k = value just after edge Ek).
module tb_push_conditioner;

    localparam int unsigned NB = 5;

    logic          clk_osc;
    logic          reset;
    logic [NB-1:0] push_raw;
    logic [NB-1:0] btn_level,  btn_press,  btn_event;
    logic [NB-1:0] btn_level8, btn_press8, btn_event8;

    int n_chk;
    int n_err;

    logic [NB-1:0] raw_seq [32];
    logic [31:0]   cap_lv  [NB];
    logic [31:0]   cap_pr  [NB];
    logic [31:0]   cap_ev  [NB];
    logic [31:0]   cap_lv8 [NB];
    logic [31:0]   cap_pr8 [NB];
    logic [31:0]   cap_ev8 [NB];

    push_conditioner #(
        .NUM_BTN(NB), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10),
        .REPEAT_PERIOD(5), .REPEAT_MASK(5'b00011), .STRETCH_CYCLES(3)
    ) u_dut (
        .clk_osc(clk_osc), .reset(reset), .push_raw(push_raw),
        .btn_level(btn_level), .btn_press(btn_press), .btn_event(btn_event)
    );

    push_conditioner #(
        .NUM_BTN(NB), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10),
        .REPEAT_PERIOD(5), .REPEAT_MASK(5'b00011), .STRETCH_CYCLES(8)
    ) u_dut8 (
        .clk_osc(clk_osc), .reset(reset), .push_raw(push_raw),
        .btn_level(btn_level8), .btn_press(btn_press8), .btn_event(btn_event8)
    );

    always #5 clk_osc = ~clk_osc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic fill(input logic [NB-1:0] v);
        for (int k = 0; k < 32; k++) raw_seq[k] = v;
    endtask

    // raw_seq[k] is the pin value sampled at edge Ek of the window.
    task automatic capture(input int n);
        for (int b = 0; b < int'(NB); b++) begin
            cap_lv[b] = '0;  cap_pr[b] = '0;  cap_ev[b] = '0;
            cap_lv8[b] = '0; cap_pr8[b] = '0; cap_ev8[b] = '0;
        end
        push_raw = raw_seq[0];
        for (int k = 0; k < n; k++) begin
            @(posedge clk_osc);
            #1;
            for (int b = 0; b < int'(NB); b++) begin
                cap_lv[b][k]  = btn_level[b];
                cap_pr[b][k]  = btn_press[b];
                cap_ev[b][k]  = btn_event[b];
                cap_lv8[b][k] = btn_level8[b];
                cap_pr8[b][k] = btn_press8[b];
                cap_ev8[b][k] = btn_event8[b];
            end
            if (k + 1 < 32) push_raw = raw_seq[k + 1];
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_osc);
        #1;
    endtask

    task automatic chk_btn(input string tag, input int b, input logic [31:0] lv,
                           input logic [31:0] pr, input logic [31:0] ev);
        chk($sformatf("%s_lv%0d", tag, b), cap_lv[b], lv);
        chk($sformatf("%s_pr%0d", tag, b), cap_pr[b], pr);
        chk($sformatf("%s_ev%0d", tag, b), cap_ev[b], ev);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_lv"},  32'(btn_level),  32'h0);
        chk({tag, "_pr"},  32'(btn_press),  32'h0);
        chk({tag, "_ev"},  32'(btn_event),  32'h0);
        chk({tag, "_ev8"}, 32'(btn_event8), 32'h0);
    endtask

    initial begin
        n_chk    = 0;
        n_err    = 0;
        clk_osc  = 1'b0;
        reset    = 1'b1;
        push_raw = '0;

        // Reset state, then quiet running with no input.
        repeat (3) @(posedge clk_osc);
        #1;
        chk_outputs_zero("rst");
        reset = 1'b0;
        idle(5);
        chk_outputs_zero("quiet");

        // Clean press on up: held E0..E29, released from E30.
        fill(5'b00001);
        raw_seq[30] = '0;
        raw_seq[31] = '0;
        capture(32);
        chk_btn("up", 0, 32'hFFFF_FFE0, 32'h8421_0040, 32'h9CE7_01C0);
        chk("up_lv8_0", cap_lv8[0], 32'hFFFF_FFE0);
        chk("up_pr8_0", cap_pr8[0], 32'h8421_0040);
        chk("up_ev8_0", cap_ev8[0], 32'hFFFF_3FC0);
        for (int b = 1; b < int'(NB); b++) chk_btn("up_other", b, 32'h0, 32'h0, 32'h0);
        // Release window E32..E63: level falls at E35, no release pulse.
        fill('0);
        capture(32);
        chk_btn("rel", 0, 32'h0000_0007, 32'h0, 32'h0000_0003);
        chk("rel_ev8_0", cap_ev8[0], 32'h0000_007F);
        idle(5);

        // Bounce on middle: 1,1,0,0,1,1,0,0 then stable high from E8.
        fill(5'b10000);
        raw_seq[2] = '0; raw_seq[3] = '0; raw_seq[6] = '0; raw_seq[7] = '0;
        capture(32);
        chk_btn("bnc", 4, 32'hFFFF_E000, 32'h0000_4000, 32'h0001_C000);
        push_raw = '0;
        idle(25);
        chk_outputs_zero("bnc_rel");

        // Glitch: 3-cycle high pulse on left.
        fill('0);
        raw_seq[0] = 5'b00100; raw_seq[1] = 5'b00100; raw_seq[2] = 5'b00100;
        capture(20);
        chk_btn("gl", 2, 32'h0, 32'h0, 32'h0);
        chk("gl_ev8_2", cap_ev8[2], 32'h0);

        // Simultaneous down + right; only down repeats.
        fill(5'b01010);
        capture(32);
        chk_btn("sim", 1, 32'hFFFF_FFE0, 32'h8421_0040, 32'h9CE7_01C0);
        chk_btn("sim", 3, 32'hFFFF_FFE0, 32'h0000_0040, 32'h0000_01C0);
        chk_btn("sim", 0, 32'h0, 32'h0, 32'h0);
        push_raw = '0;
        idle(25);
        chk_outputs_zero("sim_rel");

        // Reset during REPEAT with up held, right after the E16 repeat pulse.
        fill(5'b00001);
        capture(17);
        chk("pre_rst_pr0", 32'(btn_press[0]), 32'h1);
        reset = 1'b1;
        #2;
        chk_outputs_zero("mid_rst");
        repeat (2) @(posedge clk_osc);
        #1;
        reset = 1'b0;
        capture(32);
        chk_btn("post_rst", 0, 32'hFFFF_FFE0, 32'h8421_0040, 32'h9CE7_01C0);
        push_raw = '0;
        idle(25);
        chk_outputs_zero("end");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
